// File: rtl/spi_frame_regs_pkg.sv
// Shared constants for the SPI frame engine: frame layout, CRC polynomial, cfg fields, FSM states.
// Used by spi_frame_regs in both builds (SPI_CRC8_EN defined or not).
package spi_frame_regs_pkg;

  localparam logic [7:0] STATUS_MAGIC = 8'hA5;
  localparam int         WORD_BITS    = 32;
  localparam logic [7:0] CRC_POLY     = 8'h07;

  localparam int CFG_DIRTIME_LSB  = 0;
  localparam int CFG_STEPTIME_LSB = 4;
  localparam int CFG_STEPPOL_BIT  = 8;
  localparam int CFG_TAP_LSB      = 9;
  localparam int CFG_PWM_LSB      = 16;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_CHECK = 2'd2;

endpackage

// File: rtl/spi_frame_regs_sync.sv
// Three-flop synchroniser with rising/falling edge pulses, for the SPI SCK and SSEL pins.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic [2:0] sr;

  // shift the pin through the synchroniser; sr[2] is the previous synchronised value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= {3{RST_VAL}};
    end else begin
      sr <= {sr[1:0], pin};
    end
  end

  assign rise = sr[1] & ~sr[2];
  assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_frame_regs.sv
// N-channel SPI-slave frame engine with snapshot readback and atomic commit of written registers.
// Optional feature: define SPI_CRC8_EN for a CRC-8 trailer byte on MOSI and MISO.
module spi_frame_regs
  import spi_frame_regs_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int VW   = 12,
  parameter int PW   = 21,
  parameter int DW   = 9,
  parameter int IW   = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SCK,
  input  logic                 SSEL,
  input  logic                 MOSI,
  output logic                 MISO,
  input  logic [N_CH*PW-1:0]   pos,
  input  logic [IW-1:0]        din,
  input  logic [15:0]          rpm,
  output logic [N_CH*VW-1:0]   vel,
  output logic [DW-1:0]        dout,
  output logic [31:0]          cfg,
  output logic                 commit,
  output logic                 frame_err
);

  localparam int NW        = N_CH + 2;
  localparam int DATA_BITS = NW * WORD_BITS;
`ifdef SPI_CRC8_EN
  localparam int FRAME_BITS = DATA_BITS + 8;
`else
  localparam int FRAME_BITS = DATA_BITS;
`endif
  localparam int CW  = $clog2(DATA_BITS + 9);
  localparam int IXW = CW - 5;
  localparam logic [CW-1:0] DATA_CNT  = CW'(DATA_BITS);
  localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

`ifdef SPI_CRC8_EN
  function automatic logic [7:0] crc8(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction
`endif

  logic              sck_rise, sck_fall, ssel_rise, ssel_fall;
  logic [1:0]        mosi_pipe;
  logic              mosi_bit;
  state_t            state;
  logic              pend;
  logic              start;
  logic [CW-1:0]     cnt;
  logic [IXW-1:0]    widx;
  logic              in_data;
  logic [7:0]        rx_byte;
  logic [7:0]        rx_bits;
  logic [23:0]       rx_part;
  logic [31:0]       rx_word;
  logic [N_CH*PW-1:0] snap_pos;
  logic [IW-1:0]     snap_din;
  logic [15:0]       snap_rpm;
  logic [N_CH*VW-1:0] sh_vel;
  logic [DW-1:0]     sh_dout;
  logic [31:0]       sh_cfg;
  logic [31:0]       tx_words [NW];
  logic [31:0]       tx_word;
  logic [7:0]        tx_byte;
  logic              tx_bit;
  logic              frame_ok;
  logic [7:0]        err_cnt;
  logic [7:0]        frame_cnt;
`ifdef SPI_CRC8_EN
  logic [7:0]        crc_rx;
  logic [7:0]        crc_tx;
  logic              in_crc;
`endif

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
    .clk (clk), .rst (rst), .pin (SCK), .rise (sck_rise), .fall (sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_ssel_sync (
    .clk (clk), .rst (rst), .pin (SSEL), .rise (ssel_rise), .fall (ssel_fall)
  );

  // MOSI is delayed by two flops so it lines up with the synchronised SCK edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_pipe <= 2'b00;
    end else begin
      mosi_pipe <= {mosi_pipe[0], MOSI};
    end
  end
  assign mosi_bit = mosi_pipe[1];

  assign start = (state == ST_IDLE) && (ssel_fall || pend);

  // readback word/byte/bit selection from the frame-start snapshot
  always_comb begin
    rx_bits = {rx_byte[6:0], mosi_bit};
    rx_word = {rx_bits, rx_part};
    widx    = cnt[CW-1:5];
    in_data = (cnt < DATA_CNT);
    for (int k = 0; k < N_CH; k++) begin
      tx_words[k] = {32{1'b0}};
      tx_words[k][PW-1:0] = snap_pos[k*PW +: PW];
    end
    tx_words[N_CH]   = {snap_rpm, 16'(snap_din)};
    tx_words[N_CH+1] = {STATUS_MAGIC, 8'(N_CH), err_cnt, frame_cnt};
    tx_word = {32{1'b0}};
    for (int k = 0; k < NW; k++) begin
      tx_word = tx_word | ({32{widx == IXW'(k)}} & tx_words[k]);
    end
    tx_byte = tx_word[{cnt[4:3], 3'b000} +: 8];
`ifdef SPI_CRC8_EN
    in_crc = (cnt >= DATA_CNT) && (cnt < FRAME_CNT);
    if (in_data) begin
      tx_bit = tx_byte[~cnt[2:0]];
    end else if (in_crc) begin
      tx_bit = crc_tx[~cnt[2:0]];
    end else begin
      tx_bit = 1'b0;
    end
`else
    if (in_data) begin
      tx_bit = tx_byte[~cnt[2:0]];
    end else begin
      tx_bit = 1'b0;
    end
`endif
  end

`ifdef SPI_CRC8_EN
  assign frame_ok = (cnt == FRAME_CNT) && (rx_byte == crc_rx);
`else
  assign frame_ok = (cnt == FRAME_CNT);
`endif

  // frame FSM; an SSEL fall seen during CHECK is held until IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      pend  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SHIFT;
            pend  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (ssel_rise) state <= ST_CHECK;
        end
        ST_CHECK: begin
          state <= ST_IDLE;
          if (ssel_fall) pend <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // bit counter, byte assembly and running CRCs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= {CW{1'b0}};
      rx_byte <= 8'h00;
      rx_part <= 24'h000000;
`ifdef SPI_CRC8_EN
      crc_rx  <= 8'h00;
      crc_tx  <= 8'h00;
`endif
    end else if (start) begin
      cnt     <= {CW{1'b0}};
      rx_byte <= 8'h00;
      rx_part <= 24'h000000;
`ifdef SPI_CRC8_EN
      crc_rx  <= 8'h00;
      crc_tx  <= 8'h00;
`endif
    end else if ((state == ST_SHIFT) && sck_rise) begin
      if (cnt != CNT_MAX) cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
      rx_byte <= rx_bits;
      if (in_data && (cnt[2:0] == 3'd7)) begin
        rx_part <= {rx_bits, rx_part[23:8]};
`ifdef SPI_CRC8_EN
        crc_rx  <= crc8(crc_rx, rx_bits);
        crc_tx  <= crc8(crc_tx, tx_byte);
`endif
      end
    end
  end

  // snapshot at frame start; completed words land in the shadows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_pos <= {(N_CH*PW){1'b0}};
      snap_din <= {IW{1'b0}};
      snap_rpm <= 16'h0000;
      sh_vel   <= {(N_CH*VW){1'b0}};
      sh_dout  <= {DW{1'b0}};
      sh_cfg   <= 32'h0000_0000;
    end else if (start) begin
      snap_pos <= pos;
      snap_din <= din;
      snap_rpm <= rpm;
      sh_vel   <= {(N_CH*VW){1'b0}};
      sh_dout  <= {DW{1'b0}};
      sh_cfg   <= 32'h0000_0000;
    end else if ((state == ST_SHIFT) && sck_rise && in_data && (cnt[4:0] == 5'd31)) begin
      for (int k = 0; k < N_CH; k++) begin
        if (widx == IXW'(k)) sh_vel[k*VW +: VW] <= rx_word[VW-1:0];
      end
      if (widx == IXW'(N_CH))   sh_dout <= rx_word[DW-1:0];
      if (widx == IXW'(N_CH+1)) sh_cfg  <= rx_word;
    end
  end

  // commit or reject in CHECK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vel       <= {(N_CH*VW){1'b0}};
      dout      <= {DW{1'b0}};
      cfg       <= 32'h0000_0000;
      commit    <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= 8'h00;
      frame_cnt <= 8'h00;
    end else begin
      commit <= 1'b0;
      if (state == ST_CHECK) begin
        if (frame_ok) begin
          vel       <= sh_vel;
          dout      <= sh_dout;
          cfg       <= sh_cfg;
          commit    <= 1'b1;
          frame_err <= 1'b0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          frame_err <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

  // MISO presents bit 0 before the first SCK rise, then advances on each SCK fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MISO <= 1'b0;
    end else if (state != ST_SHIFT) begin
      MISO <= 1'b0;
    end else if (sck_fall || (cnt == {CW{1'b0}})) begin
      MISO <= tx_bit;
    end
  end

endmodule
